stream_demux_1ton: RTL
======================

STREAM_DEMUX_1TON -- requirements
Module: stream_demux_1ton

Interface
REQ-001 Parameter N_OUT, default 8: number of output channels, legal range 2..32.
REQ-002 Parameter DATA_W, default 8: payload width in bits, at least 1.
REQ-003 Parameter SEL_W, default 3: select width, at least clog2(N_OUT).
REQ-004 Parameter CNT_W, default 8: drop-counter width.
REQ-005 clk  input  1  sole clock; all state changes on the rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 in_valid  input  1  upstream offers a word.
REQ-008 in_ready  output  1  block accepts a word this cycle.
REQ-009 in_data  input  DATA_W  payload.
REQ-010 in_sel  input  SEL_W  destination channel index.
REQ-011 in_bcast  input  1  deliver to all N_OUT channels; in_sel ignored.
REQ-012 out_valid  output  N_OUT  bit i: channel i holds a word.
REQ-013 out_ready  input  N_OUT  bit i: channel i consumer accepts.
REQ-014 out_data  output  DATA_W  shared payload bus, common to all channels.
REQ-015 drop_cnt  output  CNT_W  count of words dropped for an out-of-range select.

Function
REQ-016 Transfer rules: an input transfer occurs on a cycle with in_valid=1 and in_ready=1; an output transfer on channel i occurs when out_valid[i]=1 and out_ready[i]=1.
REQ-017 State: one holding stage with hold_valid, hold_data (DATA_W bits) and pend_mask (N_OUT bits).
REQ-018 Output decode: out_valid[i] = hold_valid AND pend_mask[i]; out_data = hold_data.
REQ-019 Latency: an accepted word appears on out_valid/out_data exactly 1 cycle after the input transfer.
REQ-020 Mask load on accept:
- in_bcast=1 -> pend_mask = all ones.
- in_bcast=0 and in_sel < N_OUT -> pend_mask = one-hot(in_sel).
REQ-021 Pending clear: each output transfer clears the matching pend_mask bit. Channels of a broadcast drain independently, in any order and in any cycles.
REQ-022 Stage empty: hold_valid clears on the cycle pend_mask reaches zero, unless a new word is loaded that same cycle.
REQ-023 Ready rule: in_ready = (NOT hold_valid) OR (every set pend_mask bit has out_ready=1 this cycle). Drain and refill on the same edge, giving 1 word/cycle sustained throughput.
REQ-024 No combinational path from in_valid to in_ready; out_valid depends only on registers.
REQ-025 Out-of-range select (in_bcast=0, in_sel >= N_OUT): the word is accepted and discarded, the stage is not loaded, and drop_cnt increments by 1, saturating at all ones.
REQ-026 Once out_valid[i] is asserted, it and out_data hold stable until channel i transfers; no retraction.
REQ-027 in_ready=0 while rst_n=0.

Reset
REQ-028 On rst_n low, immediately and independent of clk: hold_valid=0, pend_mask=0, hold_data=0, drop_cnt=0, so out_valid=0 and out_data=0.
REQ-029 A reset mid-broadcast discards all pending deliveries; no channel reasserts after release.
REQ-030 The first input transfer can occur on the first rising edge with rst_n=1.

Verification (N_OUT=8, DATA_W=8, SEL_W=3)
REQ-031 Unicast: in_data=0xA5, in_sel=5, all out_ready=1 -> next cycle out_valid=0x20, out_data=0xA5; the cycle after, out_valid=0x00.
REQ-032 Backpressure: word 0x3C to sel 2 with out_ready[2]=0 for 4 cycles -> out_valid=0x04 and out_data=0x3C stable, in_ready=0; out_ready[2]=1 -> transfer, in_ready=1 in the same cycle.
REQ-033 Broadcast partial drain: in_bcast=1, data 0x77, out_ready=0x0F then 0xF0 -> out_valid 0xFF, then 0xF0, then 0x00; in_ready=1 only in the second drain cycle.
REQ-034 Streaming: 8 back-to-back words to sels 0..7, all out_ready=1 -> in_ready constantly 1; out_valid walks 0x01..0x80 one cycle behind the inputs.
REQ-035 Drop: with N_OUT=6, sel=7 sent 300 times -> no out_valid ever; drop_cnt saturates at 0xFF.
REQ-036 Reset mid-operation: rst_n low while out_valid=0xFF -> out_valid=0 and drop_cnt=0 asynchronously; stays 0 after release until a new accept.

Source files
------------

// File: rtl/stream_demux_1ton.sv
// rtl/stream_demux_1ton.sv - 1-to-N stream demultiplexer with broadcast and out-of-range drop counting
module stream_demux_1ton #(
  parameter int N_OUT  = 8,
  parameter int DATA_W = 8,
  parameter int SEL_W  = 3,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [SEL_W-1:0]  in_sel,
  input  logic              in_bcast,
  output logic [N_OUT-1:0]  out_valid,
  input  logic [N_OUT-1:0]  out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  drop_cnt
);

  localparam logic [31:0]      N_OUT_U = 32'(N_OUT);
  localparam logic [N_OUT-1:0] ONE_HOT0 = {{(N_OUT-1){1'b0}}, 1'b1};

  logic              hold_valid;
  logic [DATA_W-1:0] hold_data;
  logic [N_OUT-1:0]  pend_mask;
  logic [CNT_W-1:0]  drop_q;

  logic [N_OUT-1:0]  remain;
  logic [31:0]       sel_ext;
  logic              sel_ok;
  logic              accept;
  logic              load;
  logic              drop;
  logic [N_OUT-1:0]  new_mask;

  assign out_valid = {N_OUT{hold_valid}} & pend_mask;
  assign out_data  = hold_data;
  assign drop_cnt  = drop_q;

  // Channels still owed a delivery after this cycle's output transfers.
  assign remain   = pend_mask & ~out_ready;
  assign in_ready = rst_n & (~hold_valid | ~(|remain));

  assign sel_ext  = 32'(in_sel);
  assign sel_ok   = sel_ext < N_OUT_U;
  assign accept   = in_valid & in_ready;
  assign load     = accept & (in_bcast | sel_ok);
  assign drop     = accept & ~in_bcast & ~sel_ok;
  assign new_mask = in_bcast ? {N_OUT{1'b1}} : (ONE_HOT0 << in_sel);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
      pend_mask  <= '0;
    end else if (load) begin
      hold_valid <= 1'b1;
      hold_data  <= in_data;
      pend_mask  <= new_mask;
    end else begin
      hold_valid <= hold_valid & (|remain);
      pend_mask  <= remain;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q <= '0;
    end else if (drop && (drop_q != {CNT_W{1'b1}})) begin
      drop_q <= drop_q + 1'b1;
    end
  end

endmodule
